// File: rtl/addsub_sign_seq.sv
// addsub_sign_seq: FP add/sub front end (inverts B on subtract, orders operands by magnitude, derives eff_sub/res_sign).
// Define ADDSUB_SIGN_SEQ_FAST_EN to fold the inversion into the compare cycle (IDLE -> CMP -> OUT).
module addsub_sign_seq #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         op,
  input  logic [W-1:0] dat_a,
  input  logic [W-1:0] dat_b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] dat_x,
  output logic [W-1:0] dat_y,
  output logic         eff_sub,
  output logic         res_sign
);
  typedef enum logic [1:0] {S_IDLE, S_INV, S_CMP, S_OUT} state_t;
  state_t r_state, w_next;
  logic [W-1:0] r_a, r_b, r_x, r_y, w_flip, w_b, w_x, w_y;
  logic r_op, r_eff, r_sign, w_ge, w_tie, w_eff, w_sign;
  assign w_flip = r_op ? {~r_b[W-1], r_b[W-2:0]} : r_b;
`ifdef ADDSUB_SIGN_SEQ_FAST_EN
  localparam state_t S_ACC = S_CMP;
  assign w_b = w_flip;
`else
  localparam state_t S_ACC = S_INV;
  assign w_b = r_b;
`endif
  // A tie (including sign-only differences) keeps A in X.
  assign w_ge   = r_a[W-2:0] >= w_b[W-2:0];
  assign w_tie  = r_a[W-2:0] == w_b[W-2:0];
  assign w_x    = w_ge ? r_a : w_b;
  assign w_y    = w_ge ? w_b : r_a;
  assign w_eff  = w_x[W-1] ^ w_y[W-1];
  assign w_sign = (w_tie && w_eff) ? 1'b0 : w_x[W-1];
  always_comb begin
    w_next = r_state;
    w_next = flush ? S_IDLE :
             r_state == S_IDLE ? (in_valid ? S_ACC : S_IDLE) :
             r_state == S_INV  ? S_CMP :
             r_state == S_CMP  ? S_OUT :
             (out_ready ? S_IDLE : S_OUT);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_op    <= 1'b0;
      r_x     <= '0;
      r_y     <= '0;
      r_eff   <= 1'b0;
      r_sign  <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE && in_valid && !flush) begin
        r_a  <= dat_a;
        r_b  <= dat_b;
        r_op <= op;
      end
      if (r_state == S_INV && !flush) r_b <= w_flip;
      if (r_state == S_CMP && !flush) begin
        r_x    <= w_x;
        r_y    <= w_y;
        r_eff  <= w_eff;
        r_sign <= w_sign;
      end
    end
  end
  assign in_ready  = r_state == S_IDLE;
  assign out_valid = r_state == S_OUT;
  assign dat_x     = r_x;
  assign dat_y     = r_y;
  assign eff_sub   = r_eff;
  assign res_sign  = r_sign;
endmodule

// File: tb/tb_addsub_sign_seq.sv
// tb_addsub_sign_seq: directed literal vectors plus randomized traffic against a cycle-count reference model.
module tb_addsub_sign_seq;
`ifdef ADDSUB_SIGN_SEQ_FAST_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 3;
`endif
  logic clk = 1'b0, rst_n = 1'b0, flush = 1'b0, in_valid = 1'b0, op = 1'b0, out_ready = 1'b0;
  logic [31:0] dat_a = '0, dat_b = '0;
  logic in_ready, out_valid, eff_sub, res_sign;
  logic [31:0] dat_x, dat_y;
  int n_chk = 0, n_err = 0;
  addsub_sign_seq #(.W(32)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .dat_a(dat_a), .dat_b(dat_b), .out_valid(out_valid), .out_ready(out_ready),
    .dat_x(dat_x), .dat_y(dat_y), .eff_sub(eff_sub), .res_sign(res_sign)
  );
  always #5 clk = ~clk;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic void ref_op(input logic o, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] x, output logic [31:0] y, output logic e, output logic s);
    logic [31:0] bp;
    bp = o ? (b ^ 32'h8000_0000) : b;
    if (a[30:0] >= bp[30:0]) begin x = a; y = bp; end
    else begin x = bp; y = a; end
    e = x[31] != y[31];
    s = (a[30:0] == bp[30:0] && e) ? 1'b0 : x[31];
  endfunction
  // Model: m_age counts edges since acceptance (0 = idle); outputs valid once it reaches LAT.
  int m_age = 0;
  bit m_init = 0, m_zero = 0;
  logic [31:0] m_x, m_y, p_x, p_y;
  logic m_eff, m_sign, p_eff, p_sign;
  always @(posedge clk) begin
    if (!rst_n) begin
      m_age = 0; m_init = 1; m_zero = 1;
      m_x = '0; m_y = '0; m_eff = 0; m_sign = 0;
    end else if (m_age == 0) begin
      if (in_valid && !flush) begin
        m_age = 1;
        ref_op(op, dat_a, dat_b, p_x, p_y, p_eff, p_sign);
      end
    end else if (flush) m_age = 0;
    else if (m_age == LAT) begin
      if (out_ready) m_age = 0;
    end else begin
      m_age++;
      if (m_age == LAT) begin
        m_x = p_x; m_y = p_y; m_eff = p_eff; m_sign = p_sign; m_zero = 0;
      end
    end
  end
  always @(negedge clk) if (m_init) begin
    check("in_ready", 32'(in_ready), 32'(m_age == 0));
    check("out_valid", 32'(out_valid), 32'(m_age == LAT));
    if (m_age == LAT || m_zero) begin
      check("dat_x", dat_x, m_x);
      check("dat_y", dat_y, m_y);
      check("eff_sub", 32'(eff_sub), 32'(m_eff));
      check("res_sign", 32'(res_sign), 32'(m_sign));
    end
  end
  task automatic run_op(input logic o, input logic [31:0] a, input logic [31:0] b, input logic [31:0] ex,
                        input logic [31:0] ey, input logic ee, input logic es);
    int n;
    @(negedge clk);
    in_valid = 1; op = o; dat_a = a; dat_b = b; out_ready = 0;
    @(negedge clk);
    in_valid = 0; n = 1;
    while (!out_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("lat", 32'(n), 32'(LAT));
    check("lit_x", dat_x, ex);
    check("lit_y", dat_y, ey);
    check("lit_eff", 32'(eff_sub), 32'(ee));
    check("lit_sign", 32'(res_sign), 32'(es));
  endtask
  task automatic release_out();
    out_ready = 1;
    @(negedge clk);
    out_ready = 0;
    check("rel_valid", 32'(out_valid), 32'd0);
    check("rel_ready", 32'(in_ready), 32'd1);
  endtask
  initial begin
    int n;
    logic [31:0] a;
    repeat (2) @(negedge clk);
    check("rst_ready", 32'(in_ready), 32'd1);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_x", dat_x, 32'd0);
    rst_n = 1;
    run_op(1, 32'h4040_0000, 32'h3F80_0000, 32'h4040_0000, 32'hBF80_0000, 1, 0);
    repeat (5) begin
      @(negedge clk);
      check("hold_x", dat_x, 32'h4040_0000);
      check("hold_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1; in_valid = 1; op = 1; dat_a = 32'h3F80_0000; dat_b = 32'h4040_0000;
    @(negedge clk);
    out_ready = 0;
    check("b2b_valid", 32'(out_valid), 32'd0);
    check("b2b_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 0;
    check("b2b_acc", 32'(in_ready), 32'd0);
    n = 0;
    while (!out_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("b2b_x", dat_x, 32'hC040_0000);
    check("b2b_y", dat_y, 32'h3F80_0000);
    check("b2b_eff", 32'(eff_sub), 32'd1);
    check("b2b_sign", 32'(res_sign), 32'd1);
    release_out();
    run_op(1, 32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000, 32'hBF80_0000, 1, 0);
    release_out();
    run_op(0, 32'hBF80_0000, 32'hC000_0000, 32'hC000_0000, 32'hBF80_0000, 0, 1);
    release_out();
    @(negedge clk);
    in_valid = 1; op = 0; dat_a = 32'h1234_5678; dat_b = 32'h0000_0001;
    @(negedge clk);
    in_valid = 0;
    repeat (LAT - 2) @(negedge clk);
    flush = 1; out_ready = 1;
    @(negedge clk);
    flush = 0; out_ready = 0;
    check("flush_valid", 32'(out_valid), 32'd0);
    check("flush_ready", 32'(in_ready), 32'd1);
    repeat (4) begin
      @(negedge clk);
      check("flush_quiet", 32'(out_valid), 32'd0);
    end
    run_op(1, 32'h4040_0000, 32'h3F80_0000, 32'h4040_0000, 32'hBF80_0000, 1, 0);
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    check("rout_valid", 32'(out_valid), 32'd0);
    check("rout_x", dat_x, 32'd0);
    check("rout_y", dat_y, 32'd0);
    check("rout_eff", 32'(eff_sub), 32'd0);
    check("rout_sign", 32'(res_sign), 32'd0);
    flush = 1; in_valid = 1;
    @(negedge clk);
    flush = 0; in_valid = 0;
    check("idle_flush", 32'(in_ready), 32'd1);
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      a = $urandom;
      in_valid = $urandom_range(0, 1) == 1;
      out_ready = $urandom_range(0, 3) != 0;
      flush = $urandom_range(0, 19) == 0;
      rst_n = $urandom_range(0, 199) != 0;
      op = $urandom_range(0, 1) == 1;
      dat_a = a;
      case ($urandom_range(0, 3))
        0: dat_b = a;
        1: dat_b = a ^ 32'h8000_0000;
        2: dat_b = a + 32'(($urandom_range(0, 1) == 1) ? 1 : -1);
        default: dat_b = $urandom;
      endcase
    end
    @(negedge clk);
    rst_n = 1; in_valid = 0; flush = 0;
    repeat (4) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
